wd_multichannel: RTL and testbench

- Parametrised successor of the single-channel windowed watchdog.
- Supervises NUM_CH independent software channels, each with its own frame length, service-window length and enable bit.
- Configuration registers are key-protected; the unlock key is consumed by a single write.
- On the first channel fault it latches the fail status and drives a programmable-length system reset pulse. It sits between the CPU register bus and the board reset tree.

---
 rtl/wd_multichannel.sv | 223 ++++++++++++++++++++++
 tb/tb_wd_multichannel.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wd_multichannel.sv
// Multi-channel windowed watchdog with key-protected configuration,
// sticky first-fault capture and a programmable-length reset pulse.
module wd_multichannel #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16,
   parameter logic [15:0] KEY    = 16'hA55A,
   parameter int unsigned FW_DEF = 1000,
   parameter int unsigned SW_DEF = 100,
   parameter int unsigned RL_DEF = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              WREN,
   input  logic [2:0]        ABUS,
   input  logic [15:0]       DBUS,
   input  logic [NUM_CH-1:0] SRVC,
   output logic              RSTOUT,
   output logic              WDFAIL,
   output logic [NUM_CH-1:0] FAIL_CH,
   output logic [3:0]        FAIL_ID,
   output logic [2:0]        FLSTAT
);

   localparam int unsigned ID_W   = 4;
   localparam int unsigned CODE_W = 3;

   localparam logic [CODE_W-1:0] CODE_EARLY   = 3'b001;
   localparam logic [CODE_W-1:0] CODE_TIMEOUT = 3'b010;

   typedef enum logic {LK_LOCKED = 1'b0, LK_UNLOCKED = 1'b1} lock_e;
   typedef enum logic [1:0] {CH_IDLE, CH_CLOSED, CH_OPEN, CH_FAULT} ch_e;

   lock_e                          lock_q, lock_d;
   logic [ID_W-1:0]                ch_sel_q, ch_sel_d;
   logic [NUM_CH-1:0][CNT_W-1:0]   fwlen_q, fwlen_d;
   logic [NUM_CH-1:0][CNT_W-1:0]   swlen_q, swlen_d;
   logic [NUM_CH-1:0]              en_q, en_d;
   logic [CNT_W-1:0]               rst_lmt_q, rst_lmt_d;
   logic                           wr_ok_c;

   ch_e                            st_q [NUM_CH];
   ch_e                            st_d [NUM_CH];
   logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;
   logic [NUM_CH-1:0][CNT_W-1:0]   thr_c;
   logic [NUM_CH-1:0][CNT_W-1:0]   last_c;
   logic [NUM_CH-1:0]              open_c;
   logic [NUM_CH-1:0]              fault_c;
   logic [NUM_CH-1:0][CODE_W-1:0]  code_c;

   logic                           wdfail_q, wdfail_d;
   logic [NUM_CH-1:0]              fail_ch_q, fail_ch_d;
   logic [ID_W-1:0]                fail_id_q, fail_id_d;
   logic [CODE_W-1:0]              flstat_q, flstat_d;
   logic                           rstout_q, rstout_d;
   logic [CNT_W-1:0]               down_q, down_d;
   logic                           found_c;
   logic [ID_W-1:0]                first_id_c;
   logic [CODE_W-1:0]              first_code_c;

   // Lock FSM and register write decode; one legal write per unlock.
   always_comb begin
      lock_d    = lock_q;
      ch_sel_d  = ch_sel_q;
      fwlen_d   = fwlen_q;
      swlen_d   = swlen_q;
      en_d      = en_q;
      rst_lmt_d = rst_lmt_q;
      wr_ok_c   = 1'b0;
      if (WREN) begin
         case (lock_q)
            LK_LOCKED: begin
               if (ABUS == 3'd0 && DBUS == KEY) lock_d = LK_UNLOCKED;
            end
            LK_UNLOCKED: begin
               if (ABUS == 3'd0) begin
                  if (DBUS != KEY) lock_d = LK_LOCKED;
               end else begin
                  wr_ok_c = 1'b1;
                  lock_d  = LK_LOCKED;
               end
            end
            default: lock_d = LK_LOCKED;
         endcase
      end
      if (wr_ok_c) begin
         case (ABUS)
            3'd1: ch_sel_d = DBUS[ID_W-1:0];
            3'd2: for (int i = 0; i < int'(NUM_CH); i++)
                     if (ch_sel_q == ID_W'(i)) fwlen_d[i] = CNT_W'(DBUS);
            3'd3: for (int i = 0; i < int'(NUM_CH); i++)
                     if (ch_sel_q == ID_W'(i)) swlen_d[i] = CNT_W'(DBUS);
            3'd4: for (int i = 0; i < int'(NUM_CH); i++)
                     if (ch_sel_q == ID_W'(i)) en_d[i] = DBUS[0];
            3'd5: rst_lmt_d = CNT_W'(DBUS);
            default: ;
         endcase
      end
   end

   // Window geometry per channel from the live length registers.
   always_comb begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
         thr_c[i]  = (swlen_q[i] >= fwlen_q[i]) ? '0 : fwlen_q[i] - swlen_q[i];
         last_c[i] = fwlen_q[i] - CNT_W'(1);
         open_c[i] = (cnt_q[i] >= thr_c[i]);
      end
   end

   // Per-channel frame FSM; a fault is flagged in the cycle it is detected.
   always_comb begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
         st_d[i]    = st_q[i];
         cnt_d[i]   = cnt_q[i];
         fault_c[i] = 1'b0;
         code_c[i]  = '0;
         if (!en_q[i] || fwlen_q[i] == '0) begin
            st_d[i]  = CH_IDLE;
            cnt_d[i] = '0;
         end else begin
            case (st_q[i])
               CH_IDLE: begin
                  cnt_d[i] = '0;
                  st_d[i]  = (thr_c[i] == '0) ? CH_OPEN : CH_CLOSED;
               end
               CH_CLOSED, CH_OPEN: begin
                  if (SRVC[i]) begin
                     if (open_c[i]) begin
                        cnt_d[i] = '0;
                        st_d[i]  = (thr_c[i] == '0) ? CH_OPEN : CH_CLOSED;
                     end else begin
                        st_d[i]    = CH_FAULT;
                        fault_c[i] = 1'b1;
                        code_c[i]  = CODE_EARLY;
                     end
                  end else if (cnt_q[i] >= last_c[i]) begin
                     st_d[i]    = CH_FAULT;
                     fault_c[i] = 1'b1;
                     code_c[i]  = CODE_TIMEOUT;
                  end else begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                     st_d[i]  = (cnt_q[i] + CNT_W'(1) >= thr_c[i]) ? CH_OPEN : CH_CLOSED;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // First-fault capture, sticky fail mask and reset pulse downcounter.
   always_comb begin
      wdfail_d     = wdfail_q;
      fail_ch_d    = fail_ch_q | fault_c;
      fail_id_d    = fail_id_q;
      flstat_d     = flstat_q;
      rstout_d     = rstout_q;
      down_d       = down_q;
      found_c      = 1'b0;
      first_id_c   = '0;
      first_code_c = '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         if (fault_c[i] && !found_c) begin
            found_c      = 1'b1;
            first_id_c   = ID_W'(i);
            first_code_c = code_c[i];
         end
      end
      if (!wdfail_q && found_c) begin
         wdfail_d  = 1'b1;
         fail_id_d = first_id_c;
         flstat_d  = first_code_c;
         rstout_d  = 1'b1;
         down_d    = (rst_lmt_q == '0) ? CNT_W'(1) : rst_lmt_q;
      end else if (rstout_q) begin
         down_d = down_q - CNT_W'(1);
         if (down_q == CNT_W'(1)) rstout_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         lock_q    <= LK_LOCKED;
         ch_sel_q  <= '0;
         en_q      <= '0;
         rst_lmt_q <= CNT_W'(RL_DEF);
         for (int i = 0; i < int'(NUM_CH); i++) begin
            fwlen_q[i] <= CNT_W'(FW_DEF);
            swlen_q[i] <= CNT_W'(SW_DEF);
            st_q[i]    <= CH_IDLE;
            cnt_q[i]   <= '0;
         end
         wdfail_q  <= 1'b0;
         fail_ch_q <= '0;
         fail_id_q <= '0;
         flstat_q  <= '0;
         rstout_q  <= 1'b0;
         down_q    <= '0;
      end else begin
         lock_q    <= lock_d;
         ch_sel_q  <= ch_sel_d;
         en_q      <= en_d;
         rst_lmt_q <= rst_lmt_d;
         fwlen_q   <= fwlen_d;
         swlen_q   <= swlen_d;
         for (int i = 0; i < int'(NUM_CH); i++) st_q[i] <= st_d[i];
         cnt_q     <= cnt_d;
         wdfail_q  <= wdfail_d;
         fail_ch_q <= fail_ch_d;
         fail_id_q <= fail_id_d;
         flstat_q  <= flstat_d;
         rstout_q  <= rstout_d;
         down_q    <= down_d;
      end
   end

   assign RSTOUT  = rstout_q;
   assign WDFAIL  = wdfail_q;
   assign FAIL_CH = fail_ch_q;
   assign FAIL_ID = fail_id_q;
   assign FLSTAT  = flstat_q;

endmodule

// File: tb/tb_wd_multichannel.sv
// Bench for wd_multichannel: table of single-channel frame scenarios plus
// hand-written multi-cycle sequences, checked through an edge-indexed scoreboard.
module tb_wd_multichannel;

   localparam int unsigned NCH = 4;
   localparam logic [15:0] K   = 16'hA55A;

   logic            CLK = 1'b0;
   logic            RST = 1'b0;
   logic            WREN = 1'b0;
   logic [2:0]      ABUS = '0;
   logic [15:0]     DBUS = '0;
   logic [NCH-1:0]  SRVC = '0;
   logic            RSTOUT, WDFAIL;
   logic [NCH-1:0]  FAIL_CH;
   logic [3:0]      FAIL_ID;
   logic [2:0]      FLSTAT;

   wd_multichannel #(.NUM_CH(NCH)) dut (
      .CLK(CLK), .RST(RST), .WREN(WREN), .ABUS(ABUS), .DBUS(DBUS), .SRVC(SRVC),
      .RSTOUT(RSTOUT), .WDFAIL(WDFAIL), .FAIL_CH(FAIL_CH), .FAIL_ID(FAIL_ID),
      .FLSTAT(FLSTAT)
   );

   always #5 CLK = ~CLK;

   int unsigned edges = 0;
   always @(posedge CLK) edges <= edges + 1;

   typedef struct {
      int unsigned cyc;
      string       name;
      logic [12:0] exp;
   } sb_t;

   typedef struct {
      string      name;
      int         fw;
      int         sw;
      int         kick;
      logic [2:0] code;
      int         foff;
   } row_t;

   sb_t  sbq[$];
   row_t rows[9];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [12:0] pk(input logic r, input logic w, input logic [3:0] ch,
                                      input logic [3:0] id, input logic [2:0] fl);
      return {r, w, ch, id, fl};
   endfunction

   // Queue an expected output vector for a given edge, kept in edge order.
   task automatic expect_at(input int unsigned c, input string n, input logic [12:0] e);
      sb_t s;
      int  idx;
      s.cyc = c; s.name = n; s.exp = e;
      idx = sbq.size();
      for (int j = 0; j < sbq.size(); j++) begin
         if (sbq[j].cyc > c) begin
            idx = j;
            break;
         end
      end
      sbq.insert(idx, s);
   endtask

   // Compare outputs 2 time units after each edge against due entries.
   always @(posedge CLK) begin : mon
      sb_t         e;
      logic [12:0] got;
      #2;
      got = {RSTOUT, WDFAIL, FAIL_CH, FAIL_ID, FLSTAT};
      while (sbq.size() > 0 && sbq[0].cyc <= edges) begin
         e = sbq.pop_front();
         total++;
         if (e.cyc != edges || got != e.exp) begin
            bad++;
            $display("FAIL %s edge=%0d: got rst=%b wdf=%b ch=%b id=%0d fl=%b, want rst=%b wdf=%b ch=%b id=%0d fl=%b",
                     e.name, edges, got[12], got[11], got[10:7], got[6:3], got[2:0],
                     e.exp[12], e.exp[11], e.exp[10:7], e.exp[6:3], e.exp[2:0]);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_until(input int unsigned n);
      while (edges < n) tick();
   endtask

   task automatic wr(input logic [2:0] a, input logic [15:0] d);
      ABUS = a; DBUS = d; WREN = 1'b1;
      tick();
      WREN = 1'b0;
   endtask

   task automatic cfg_wr(input logic [2:0] a, input logic [15:0] d);
      wr(3'd0, K);
      wr(a, d);
   endtask

   task automatic kick(input logic [NCH-1:0] m);
      SRVC = m;
      tick();
      SRVC = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      expect_at(edges, "reset", '0);
   endtask

   initial begin : stim
      int unsigned e, f, e3, e1, l;

      // name, FWLEN, SWLEN, kick at cnt (-1 none), fault code, fault edge after enable
      rows[0] = '{"early3",  10, 4,  3, 3'b001,  5};
      rows[1] = '{"early5",  10, 4,  5, 3'b001,  7};
      rows[2] = '{"ok6",     10, 4,  6, 3'b010, 18};
      rows[3] = '{"ok9",     10, 4,  9, 3'b010, 21};
      rows[4] = '{"nokick",  10, 4, -1, 3'b010, 11};
      rows[5] = '{"open0",    8, 8,  0, 3'b010, 10};
      rows[6] = '{"wide",     8, 20, -1, 3'b010,  9};
      rows[7] = '{"sw0",      5, 0,  4, 3'b001,  6};
      rows[8] = '{"fw2",      2, 1,  1, 3'b010,  5};

      tick();
      foreach (rows[r]) begin
         do_reset();
         cfg_wr(3'd2, 16'(rows[r].fw));
         cfg_wr(3'd3, 16'(rows[r].sw));
         cfg_wr(3'd4, 16'd1);
         e = edges;
         f = e + rows[r].foff;
         expect_at(f - 1, {rows[r].name, "_pre"}, '0);
         expect_at(f, rows[r].name, pk(1'b1, 1'b1, 4'b0001, 4'd0, rows[r].code));
         if (rows[r].kick >= 0) begin
            wait_until(e + 1 + rows[r].kick);
            kick(4'b0001);
         end
         wait_until(f + 1);
      end

      // Lock: stray writes ignored, wrong key relocks, double key stays open.
      do_reset();
      wr(3'd2, 16'd5);
      wr(3'd0, K);
      wr(3'd0, 16'h1234);
      wr(3'd2, 16'd3);
      wr(3'd0, K);
      wr(3'd2, 16'd5);
      wr(3'd2, 16'd7);
      wr(3'd0, K);
      wr(3'd0, K);
      wr(3'd4, 16'd1);
      e = edges;
      expect_at(e + 5, "lock_pre", '0);
      expect_at(e + 6, "lock_fw5", pk(1'b1, 1'b1, 4'b0001, 4'd0, 3'b010));
      wait_until(e + 7);

      // Regular service at cnt=6 for ~100 cycles, then an early kick.
      do_reset();
      cfg_wr(3'd2, 16'd10);
      cfg_wr(3'd3, 16'd4);
      cfg_wr(3'd4, 16'd1);
      e = edges;
      for (int n = 0; n < 15; n++) begin
         wait_until(e + 7 + 7 * n);
         expect_at(e + 8 + 7 * n, "svc_ok", '0);
         kick(4'b0001);
      end
      l = e + 8 + 7 * 14;
      wait_until(l + 3);
      expect_at(l + 3, "early_pre", '0);
      expect_at(l + 4, "early_late", pk(1'b1, 1'b1, 4'b0001, 4'd0, 3'b001));
      kick(4'b0001);
      wait_until(l + 5);

      // Ch2 timeout with a 16-cycle reset pulse.
      do_reset();
      cfg_wr(3'd1, 16'd2);
      cfg_wr(3'd2, 16'd8);
      cfg_wr(3'd3, 16'd8);
      cfg_wr(3'd4, 16'd1);
      e = edges;
      f = e + 9;
      for (int unsigned c = e + 8; c <= e + 26; c++) begin
         if (c < f) expect_at(c, "ch2_pre", '0);
         else expect_at(c, "ch2_pulse", pk(c < f + 16, 1'b1, 4'b0100, 4'd2, 3'b010));
      end
      wait_until(e + 27);

      // Ch1 and ch3 time out together, then ch0 kicks early.
      do_reset();
      cfg_wr(3'd4, 16'd1);
      cfg_wr(3'd1, 16'd1);
      cfg_wr(3'd2, 16'd20);
      cfg_wr(3'd3, 16'd20);
      cfg_wr(3'd1, 16'd3);
      cfg_wr(3'd2, 16'd24);   // ch3 enabled 4 edges before ch1
      cfg_wr(3'd3, 16'd40);
      cfg_wr(3'd4, 16'd1);
      e3 = edges;
      cfg_wr(3'd1, 16'd1);
      cfg_wr(3'd4, 16'd1);
      e1 = edges;
      f = e1 + 21;
      expect_at(f - 1, "dual_pre", '0);
      expect_at(f, "dual", pk(1'b1, 1'b1, 4'b1010, 4'd1, 3'b010));
      expect_at(f + 2, "dual_hold", pk(1'b1, 1'b1, 4'b1010, 4'd1, 3'b010));
      expect_at(f + 3, "dual_late0", pk(1'b1, 1'b1, 4'b1011, 4'd1, 3'b010));
      wait_until(f + 2);
      kick(4'b0001);
      wait_until(f + 4);
      if (e1 != e3 + 4) begin
         total++; bad++;
         $display("FAIL dual_setup: enable gap %0d, need 4", e1 - e3);
      end

      // RST_LMT=0 gives a single-cycle pulse.
      do_reset();
      cfg_wr(3'd5, 16'd0);
      cfg_wr(3'd2, 16'd4);
      cfg_wr(3'd3, 16'd4);
      cfg_wr(3'd4, 16'd1);
      e = edges;
      expect_at(e + 4, "rl0_pre", '0);
      expect_at(e + 5, "rl0_on", pk(1'b1, 1'b1, 4'b0001, 4'd0, 3'b010));
      expect_at(e + 6, "rl0_off", pk(1'b0, 1'b1, 4'b0001, 4'd0, 3'b010));
      wait_until(e + 7);

      // RST during a pulse clears everything and disables channels.
      do_reset();
      cfg_wr(3'd2, 16'd4);
      cfg_wr(3'd3, 16'd4);
      cfg_wr(3'd4, 16'd1);
      e = edges;
      expect_at(e + 7, "pulse_mid", pk(1'b1, 1'b1, 4'b0001, 4'd0, 3'b010));
      expect_at(e + 8, "rst_in_pulse", '0);
      expect_at(e + 1020, "rst_disabled", '0);
      wait_until(e + 7);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      wait_until(e + 1021);

      // FWLEN shrunk below the running count times out next cycle.
      do_reset();
      cfg_wr(3'd4, 16'd1);
      e = edges;
      wait_until(e + 20);
      wr(3'd0, K);
      wr(3'd2, 16'd10);
      expect_at(e + 22, "shrink_pre", '0);
      expect_at(e + 23, "shrink", pk(1'b1, 1'b1, 4'b0001, 4'd0, 3'b010));
      wait_until(e + 24);

      // Clearing enable mid-frame parks the channel without a fault.
      do_reset();
      cfg_wr(3'd4, 16'd1);
      e = edges;
      wait_until(e + 20);
      wr(3'd0, K);
      wr(3'd4, 16'd0);
      expect_at(e + 23, "disable", '0);
      expect_at(e + 1100, "disable_late", '0);
      wait_until(e + 1102);

      tick();
      tick();
      while (sbq.size() > 0) begin
         total++; bad++;
         $display("FAIL %s: never checked (edge %0d)", sbq[0].name, sbq[0].cyc);
         void'(sbq.pop_front());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
